// File: rtl/delta_decode.sv
// Delta-modulation decoder: saturating integrator, clamp to 0..255, then a
// 2^AVG_LOG2-sample moving average with a one-cycle valid per full-window push.
module delta_decode #(
  parameter int STEP     = 20,
  parameter int AVG_LOG2 = 2
) (
  input  logic       CLK100MHZ,
  input  logic       reset_n,
  input  logic       start,
  input  logic       bit_in,
  input  logic       clear,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       sat
);

  localparam int ACC_W = 10;
  localparam int N     = 1 << AVG_LOG2;
  localparam int SW    = 8 + AVG_LOG2;
  localparam int CW    = 4;

  typedef logic signed [ACC_W:0] wide_t;
  localparam wide_t ACC_MAX = 11'sd511;
  localparam wide_t ACC_MIN = -11'sd512;
  localparam wide_t STEP_S  = wide_t'(STEP);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  function automatic logic signed [ACC_W-1:0] sat_acc(input wide_t x);
    if (x > ACC_MAX) return ACC_MAX[ACC_W-1:0];
    if (x < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    return x[ACC_W-1:0];
  endfunction

  function automatic logic overflows(input wide_t x);
    return (x > ACC_MAX) || (x < ACC_MIN);
  endfunction

  function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] a);
    if (a < 0) return 8'h00;
    if (a > 10'sd255) return 8'hFF;
    return a[7:0];
  endfunction

  logic signed [ACC_W-1:0] acc_p0;
  logic                    vld_p0;
  logic [7:0]              win_p1 [N];
  logic [SW-1:0]           sum_p1;
  logic                    vld_p1;
  state_t                  state_q, state_nxt;
  logic [CW-1:0]           cnt_q, cnt_nxt;
  logic                    push, fill_run;
  wide_t                   acc_wide;
  logic [7:0]              samp;
  logic [SW-1:0]           sum_nxt;

  assign acc_wide = wide_t'(acc_p0) + (bit_in ? STEP_S : -STEP_S);
  assign push     = vld_p0 & ~clear;
  assign samp     = clamp8(acc_p0);
  assign sum_nxt  = sum_p1 + SW'(samp) - SW'(win_p1[N-1]);

  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (push && state_q != RUN) begin
      cnt_nxt   = cnt_q + CW'(1);
      state_nxt = (cnt_nxt == CW'(N)) ? RUN : FILL;
    end
  end

  always_comb begin
    fill_run = push && (state_nxt == RUN);
  end

  // S1: integrate the accepted bit
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      acc_p0 <= '0;
      vld_p0 <= 1'b0;
      sat    <= 1'b0;
    end else if (clear) begin
      acc_p0 <= '0;
      vld_p0 <= 1'b0;
      sat    <= 1'b0;
    end else begin
      vld_p0 <= start;
      if (start) begin
        acc_p0 <= sat_acc(acc_wide);
        if (overflows(acc_wide)) sat <= 1'b1;
      end
    end
  end

  // S2: push clamped sample into the averaging window
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) win_p1[i] <= '0;
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) win_p1[i] <= '0;
      sum_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= fill_run;
      if (push) begin
        for (int i = N - 1; i > 0; i--) win_p1[i] <= win_p1[i-1];
        win_p1[0] <= samp;
        sum_p1    <= sum_nxt;
      end
    end
  end

  // S3: publish the average; data_out holds between pulses and across clear
  always_ff @(posedge CLK100MHZ or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= 8'h00;
      valid    <= 1'b0;
    end else begin
      valid <= vld_p1 & ~clear;
      if (vld_p1 && !clear) data_out <= 8'(sum_p1 >> AVG_LOG2);
    end
  end

endmodule

// File: tb/tb_delta_decode.sv
// Bench for delta_decode: directed scenarios plus random traffic, all checked
// against a sample-history model of integrator, clamp and moving average.
module tb_delta_decode;

  localparam int STEP = 20;
  localparam int N    = 4;

  logic       CLK100MHZ = 1'b0;
  logic       reset_n   = 1'b1;
  logic       start     = 1'b0;
  logic       bit_in    = 1'b0;
  logic       clear     = 1'b0;
  logic [7:0] data_out;
  logic       valid;
  logic       sat;
  bit         clk_run   = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int m_acc  = 0;
  bit m_sat  = 1'b0;
  int m_dout = 0;
  bit exp_valid;
  int s_val[$];
  int s_cyc[$];
  int saved;

  delta_decode #(.STEP(STEP), .AVG_LOG2(2)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset_n   (reset_n),
    .start     (start),
    .bit_in    (bit_in),
    .clear     (clear),
    .data_out  (data_out),
    .valid     (valid),
    .sat       (sat)
  );

  always #5 if (clk_run) CLK100MHZ = ~CLK100MHZ;

  function automatic int clampi(int a);
    if (a < 0) return 0;
    if (a > 255) return 255;
    return a;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    s_val.delete();
    s_cyc.delete();
    m_acc = 0;
    m_sat = 1'b0;
  endtask

  // One clock: drive inputs, advance the model by the edge, compare outputs.
  task automatic step(bit st, bit b, bit clr);
    start  = st;
    bit_in = b;
    clear  = clr;
    @(posedge CLK100MHZ);
    cyc++;
    exp_valid = 1'b0;
    if (clr) begin
      model_clear();
    end else begin
      if (st) begin
        int t;
        t = m_acc + (b ? STEP : -STEP);
        if (t > 511) begin t = 511; m_sat = 1'b1; end
        else if (t < -512) begin t = -512; m_sat = 1'b1; end
        m_acc = t;
        s_val.push_back(clampi(t));
        s_cyc.push_back(cyc);
      end
      // A sample accepted two edges ago reports iff it completed a full window.
      foreach (s_cyc[i]) begin
        if (s_cyc[i] == cyc - 2 && i + 1 >= N) begin
          int s;
          s = 0;
          for (int j = i - N + 1; j <= i; j++) s += s_val[j];
          m_dout    = s / N;
          exp_valid = 1'b1;
        end
      end
    end
    #1;
    chk("valid", valid, exp_valid);
    chk("data_out", data_out, m_dout);
    chk("sat", sat, m_sat);
  endtask

  // Reset pulse placed between clock edges.
  task automatic async_rst(string tag);
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    m_dout = 0;
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_data"}, data_out, 0);
    chk({tag, "_sat"}, sat, 0);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_sat", sat, 0);
    clk_run = 1'b1;
    #1 reset_n = 1'b1;

    // Ramp
    repeat (4) step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("ramp_data", data_out, 50);

    // Underflow clamp
    async_rst("rst2");
    repeat (6) step(1, 0, 0);
    repeat (2) step(0, 0, 0);
    chk("under_data", data_out, 0);
    chk("under_sat", sat, 0);

    // Saturation, then one step down and a long descent
    async_rst("rst3");
    repeat (25) step(1, 1, 0);
    chk("sat_pre", sat, 0);
    repeat (5) step(1, 1, 0);
    repeat (2) step(0, 0, 0);
    chk("sat_data", data_out, 255);
    chk("sat_flag", sat, 1);
    step(1, 0, 0);
    repeat (16) step(1, 0, 0);
    repeat (2) step(0, 0, 0);

    // Clear colliding with a strobe mid-run
    repeat (6) step(1, 1, 0);
    saved = int'(data_out);
    step(1, 1, 1);
    repeat (3) step(1, 1, 0);
    chk("clr_hold", data_out, saved);
    step(1, 1, 0);
    repeat (2) step(0, 0, 0);
    chk("clr_data", data_out, 50);

    // Async reset with pushes in flight
    repeat (6) step(1, 1, 0);
    async_rst("rst4");
    repeat (3) step(1, 1, 0);
    repeat (2) step(0, 0, 0);
    step(1, 1, 0);
    repeat (2) step(0, 0, 0);
    chk("arst_data", data_out, 50);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) async_rst("rrst");
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 55),
           ($urandom_range(0, 59) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delta_decode.md
DELTA_DECODE -- requirements
Module: delta_decode

Interface
REQ-001 The block SHALL have parameter STEP, default 20, giving the unsigned integrator step per bit (range 1..127).
REQ-002 The block SHALL have parameter AVG_LOG2, default 2, giving the moving-average window of 2^AVG_LOG2 samples (range 0..3).
REQ-003 The block SHALL have port CLK100MHZ, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: bit strobe; bit_in is accepted on each rising edge where start=1.
REQ-006 The block SHALL have port bit_in, input, 1 bit: delta-modulated bit, 1 = step up, 0 = step down.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous restart of the decoder.
REQ-008 The block SHALL have port data_out, output, 8 bits: reconstructed, filtered unsigned sample.
REQ-009 The block SHALL have port valid, output, 1 bit: one-cycle pulse marking a new data_out.
REQ-010 The block SHALL have port sat, output, 1 bit: sticky integrator-saturation flag.

Function
REQ-011 The block SHALL hold a 10-bit signed integrator acc and update it on each accepted bit: acc+STEP for bit_in=1, acc-STEP for bit_in=0.
REQ-012 The integrator SHALL saturate at +511 and -512 rather than wrap, and SHALL set sat=1 on any update that saturates.
REQ-013 The clamped sample SHALL be acc limited to 0..255: negative values give 0, values above 255 give 255.
REQ-014 Pipeline stage S1 SHALL register acc at edge k, the edge where the bit is accepted.
REQ-015 Pipeline stage S2 SHALL, at edge k+1, push the clamped sample into a 2^AVG_LOG2-deep shift window and update a running sum (8+AVG_LOG2 bits, exact): sum = sum + new - oldest.
REQ-016 Pipeline stage S3 SHALL, at edge k+2, register data_out = sum >> AVG_LOG2 (truncating) and pulse valid=1 for exactly one cycle, provided the window is full after the push.
REQ-017 Strobes on consecutive cycles SHALL be supported at full rate, giving one valid per accepted bit once the window is full.
REQ-018 The block SHALL implement a state machine with three states: IDLE (no samples), FILL (1..2^AVG_LOG2-1 samples), RUN (window full).
REQ-019 State transitions SHALL be: IDLE->FILL on the first push; FILL->RUN on the push that fills the window; RUN stays in RUN; any state goes to IDLE on clear.
REQ-020 When AVG_LOG2=0, the first push SHALL go IDLE->RUN directly.
REQ-021 The block SHALL assert valid only for pushes that leave the state in RUN, and SHALL NOT assert valid for pushes made during FILL.
REQ-022 Between valid pulses, data_out SHALL hold its last value.
REQ-023 On clear=1, the block SHALL set acc, the window, sum and sat to 0, set the state to IDLE, and cancel in-flight S1/S2 pushes and pending valid; data_out SHALL hold its value.
REQ-024 When clear=1 and start=1 occur in the same cycle, clear SHALL win and the bit SHALL be discarded.
REQ-025 When start=0, acc, the window and the state SHALL be unchanged, and bit_in SHALL be ignored.

Reset
REQ-026 While reset_n=0, without waiting for a clock edge, the block SHALL force acc=0, window=0, sum=0, state=IDLE, pipeline valids=0, data_out=0x00, valid=0 and sat=0.
REQ-027 Reset deasserting mid-stream SHALL discard all pending pipeline data.
REQ-028 The first bit accepted after reset_n rises SHALL be treated as sample 1 of a new fill.

Verification
REQ-029 Reset scenario: reset_n=0 with no clock edges -> data_out=0x00, valid=0, sat=0 immediately.
REQ-030 Ramp scenario (STEP=20, AVG_LOG2=2): bits 1,1,1,1 on 4 consecutive cycles -> acc 20,40,60,80; exactly one valid, 2 cycles after the 4th bit, with data_out=50; no valid before it.
REQ-031 Underflow-clamp scenario: 6 bits of 0 after reset -> acc=-120; valid pulses with data_out=0 after bits 4, 5 and 6; sat=0.
REQ-032 Saturation scenario: 30 bits of 1 -> acc=511 from bit 26 on, sat=1 from bit 26, data_out=255 once the window holds only clamped 255s; after this, a single 0 bit -> acc=491.
REQ-033 Clear-collision scenario: clear=1 and start=1 on the same cycle mid-RUN -> acc=0, sat=0, state IDLE, no valid for the next 3 bits, valid on the 4th bit; data_out unchanged until then.
REQ-034 Async-reset scenario: reset_n pulsed low between clock edges during RUN with pushes in flight -> outputs reset immediately; no valid appears after release until 4 new bits have been accepted.
